// File: rtl/seg_regfile_sb_pkg.sv
// Shared definitions for the segment register file and its scoreboard.
// Default geometry and the architectural segment register numbering.
package seg_regfile_sb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_NRD   = 2;

    // Indices 6 and 7 exist in the array but carry no segment meaning.
    typedef enum logic [2:0] {
        ES   = 3'd0,
        CS   = 3'd1,
        SS   = 3'd2,
        DS   = 3'd3,
        FS   = 3'd4,
        GS   = 3'd5,
        RSV6 = 3'd6,
        RSV7 = 3'd7
    } seg_idx_e;

endpackage

// File: rtl/seg_rf_entry.sv
// One segment register: data word plus its pending-load busy bit.
// The busy bit gives flush precedence over issue, and issue over write-back.
module seg_rf_entry
    import seg_regfile_sb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_hit,
    input  logic             iss_hit,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data,
    output logic             busy
);

    logic busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = 1'b0;
        end else if (iss_hit) begin
            busy_nxt = 1'b1;
        end else if (wr_hit) begin
            busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            busy <= 1'b0;
        end else begin
            if (wr_hit) begin
                data <= wr_data;
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/seg_regfile_sb.sv
// Parametrised segment register file with per-register busy scoreboard,
// multi-port bypassed reads and read-side stall generation.
module seg_regfile_sb
    import seg_regfile_sb_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NRD   = DEF_NRD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_reg,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_reg,
    input  logic                 flush,
    input  logic [NRD-1:0]       rd_vld,
    input  logic [NRD*AW-1:0]    rd_reg,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_stall,
    output logic [DEPTH-1:0]     busy_vec,
    output logic                 iss_err
);

    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] iss_hit;
    logic [DEPTH-1:0] busy;
    logic [WIDTH-1:0] regs [DEPTH];
    logic             err_set;

    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_hit[k]  = wr_en  && (wr_reg  == AW'(k));
            iss_hit[k] = iss_en && (iss_reg == AW'(k));
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        seg_rf_entry #(
            .WIDTH(WIDTH)
        ) u_entry (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_hit (wr_hit[k]),
            .iss_hit(iss_hit[k]),
            .flush  (flush),
            .wr_data(wr_data),
            .data   (regs[k]),
            .busy   (busy[k])
        );
    end

    // A same-cycle write both forwards its data and releases the stall.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] idx;
        logic          byp;

        assign idx = rd_reg[i*AW +: AW];
        assign byp = wr_en && (wr_reg == idx);

        assign rd_data[i*WIDTH +: WIDTH] = byp ? wr_data : regs[idx];
        assign rd_stall[i] = rd_vld[i] && busy[idx] && !byp;
    end

    assign busy_vec = busy;

    // Re-issue to a busy register with no rescuing write is a sticky error.
    assign err_set = iss_en && busy[iss_reg] && !flush
                  && !(wr_en && (wr_reg == iss_reg));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_err <= 1'b0;
        end else if (err_set) begin
            iss_err <= 1'b1;
        end
    end

endmodule
